// File: rtl/mram_arb_ctrl_pkg.sv
// Shared types and constants for the MRAM two-requester arbiter/sequencer.
// Pin idle levels are also the reset levels of the array interface.
package mram_arb_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_TURN
   } state_e;

   localparam int DATA_W = 16;
   localparam int BE_LO  = 0;
   localparam int BE_HI  = 1;
   localparam int STAT_W = 32;

   // Array pins at rest: deselected, read direction, both byte lanes off, dq released
   localparam logic EN_IDLE   = 1'b0;
   localparam logic WE_IDLE   = 1'b1;
   localparam logic BYTE_IDLE = 1'b1;
   localparam logic OE_IDLE   = 1'b0;

   typedef struct packed {
      logic       we;
      logic [1:0] be;
      logic       port;
   } cmd_t;

   function automatic logic [DATA_W-1:0] be_mask(input logic [1:0] be);
      return {{8{be[BE_HI]}}, {8{be[BE_LO]}}};
   endfunction

   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
      return (&v) ? v : v + STAT_W'(1);
   endfunction

endpackage

// File: rtl/mram_rr_arb2.sv
// Two-way round-robin winner selection. The pointer holds the last granted
// port; with both requesting, the other port wins.
module mram_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (&req) gnt = last_q ? 2'b01 : 2'b10;
         else      gnt = req;
      end
   end

   // Reset to port 1 so port 0 wins the first conflict
   always_ff @(posedge clk) begin
      if (rst)       last_q <= 1'b1;
      else if (|gnt) last_q <= gnt[1];
   end

endmodule

// File: rtl/mram_arb_ctrl.sv
// Arbiter and pin sequencer for the 16-bit MRAM array: IDLE -> ACCESS -> (WAIT -> TURN) -> IDLE.
// Define MRAM_ARB_CTRL_STATS_EN to add saturating read/write/conflict counters.
module mram_arb_ctrl
   import mram_arb_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 20,
   parameter int RD_LAT     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [1:0]            req0_be,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_W-1:0]     req0_wdata,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [1:0]            req1_be,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_W-1:0]     req1_wdata,
   output logic                  rsp0_valid,
   output logic [DATA_W-1:0]     rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_W-1:0]     rsp1_rdata,
   output logic                  mram_enable,
   output logic                  mram_write_en,
   output logic                  mram_lb_enable,
   output logic                  mram_ub_enable,
   output logic [ADDR_WIDTH-1:0] mram_addr,
   output logic [DATA_W-1:0]     mram_dq_out,
   output logic                  mram_dq_oe,
   input  logic [DATA_W-1:0]     mram_dq_in
`ifdef MRAM_ARB_CTRL_STATS_EN
   ,
   output logic [STAT_W-1:0]     stat_rd_cnt,
   output logic [STAT_W-1:0]     stat_wr_cnt,
   output logic [STAT_W-1:0]     stat_conflict_cnt
`endif
);

   state_e                state_q, state_d;
   cmd_t                  cmd_q;
   logic [1:0]            gnt;
   logic                  arb_en;
   logic                  xfer;
   logic                  sel;
   logic                  sel_we;
   logic [1:0]            sel_be;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_W-1:0]     sel_wdata;
   logic [RD_LAT:0]       vld_pipe;
   logic [DATA_W-1:0]     rd_cap_q;
   logic                  rd_done;
   logic                  rsp_fire;

   // Arbitration is only open in IDLE and never while reset is held
   assign arb_en = (state_q == ST_IDLE) && !rst;

   mram_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .en  (arb_en),
      .req ({req1_valid, req0_valid}),
      .gnt (gnt)
   );

   assign req0_ready = gnt[0];
   assign req1_ready = gnt[1];
   assign xfer       = |gnt;
   assign sel        = gnt[1];
   assign sel_we     = sel ? req1_we    : req0_we;
   assign sel_be     = sel ? req1_be    : req0_be;
   assign sel_addr   = sel ? req1_addr  : req0_addr;
   assign sel_wdata  = sel ? req1_wdata : req0_wdata;

   always_comb begin
      state_d  = state_q;
      rd_done  = 1'b0;
      rsp_fire = 1'b0;
      case (state_q)
         ST_IDLE:   if (xfer) state_d = ST_ACCESS;
         ST_ACCESS: state_d = cmd_q.we ? ST_IDLE : ST_WAIT;
         ST_WAIT: begin
            if (vld_pipe[RD_LAT]) begin
               rd_done = 1'b1;
               state_d = ST_TURN;
            end
         end
         ST_TURN: begin
            rsp_fire = 1'b1;
            state_d  = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase
   end

   // vld_pipe[k] marks the k-th cycle after a read access; bit RD_LAT is the capture cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cmd_q    <= '0;
         vld_pipe <= '0;
         rd_cap_q <= '0;
      end else begin
         state_q  <= state_d;
         vld_pipe <= {vld_pipe[RD_LAT-1:0], xfer & ~sel_we};
         if (xfer)    cmd_q    <= '{we: sel_we, be: sel_be, port: sel};
         if (rd_done) rd_cap_q <= mram_dq_in & be_mask(cmd_q.be);
      end
   end

   // Pins are loaded straight from the winning request, so ACCESS lasts exactly one cycle
   always_ff @(posedge clk) begin
      if (rst || !xfer) begin
         mram_enable    <= EN_IDLE;
         mram_write_en  <= WE_IDLE;
         mram_lb_enable <= BYTE_IDLE;
         mram_ub_enable <= BYTE_IDLE;
         mram_addr      <= '0;
         mram_dq_out    <= '0;
         mram_dq_oe     <= OE_IDLE;
      end else begin
         mram_enable    <= 1'b1;
         mram_write_en  <= ~sel_we;
         mram_lb_enable <= ~sel_be[BE_LO];
         mram_ub_enable <= ~sel_be[BE_HI];
         mram_addr      <= sel_addr;
         mram_dq_out    <= sel_we ? sel_wdata : '0;
         mram_dq_oe     <= sel_we;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= rsp_fire && !cmd_q.port;
         rsp1_valid <= rsp_fire &&  cmd_q.port;
         if (rsp_fire && !cmd_q.port) rsp0_rdata <= rd_cap_q;
         if (rsp_fire &&  cmd_q.port) rsp1_rdata <= rd_cap_q;
      end
   end

`ifdef MRAM_ARB_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_cnt       <= '0;
         stat_wr_cnt       <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (xfer && !sel_we) stat_rd_cnt <= sat_inc(stat_rd_cnt);
         if (xfer &&  sel_we) stat_wr_cnt <= sat_inc(stat_wr_cnt);
         if (state_q == ST_IDLE && req0_valid && req1_valid)
            stat_conflict_cnt <= sat_inc(stat_conflict_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_mram_arb_ctrl.sv
// Bench for mram_arb_ctrl: directed steps then random traffic, checked each cycle
// against a transaction-level model (grant rule, busy-until cycle, expected responses).
module tb_mram_arb_ctrl;

   localparam int AW = 20;
   localparam int RL = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mem_init = 1'b0;

   logic            v   [2];
   logic            we  [2];
   logic [1:0]      be  [2];
   logic [AW-1:0]   addr[2];
   logic [15:0]     wd  [2];

   logic            req0_ready, req1_ready;
   logic            rsp0_valid, rsp1_valid;
   logic [15:0]     rsp0_rdata, rsp1_rdata;
   logic            mram_enable, mram_write_en, mram_lb_enable, mram_ub_enable;
   logic [AW-1:0]   mram_addr;
   logic [15:0]     mram_dq_out;
   logic            mram_dq_oe;
   logic [15:0]     mram_dq_in;
`ifdef MRAM_ARB_CTRL_STATS_EN
   logic [31:0]     stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt;
`endif

   always #5 clk = ~clk;

   mram_arb_ctrl #(.ADDR_WIDTH(AW), .RD_LAT(RL)) dut (
      .clk            (clk),
      .rst            (rst),
      .req0_valid     (v[0]),
      .req0_ready     (req0_ready),
      .req0_we        (we[0]),
      .req0_be        (be[0]),
      .req0_addr      (addr[0]),
      .req0_wdata     (wd[0]),
      .req1_valid     (v[1]),
      .req1_ready     (req1_ready),
      .req1_we        (we[1]),
      .req1_be        (be[1]),
      .req1_addr      (addr[1]),
      .req1_wdata     (wd[1]),
      .rsp0_valid     (rsp0_valid),
      .rsp0_rdata     (rsp0_rdata),
      .rsp1_valid     (rsp1_valid),
      .rsp1_rdata     (rsp1_rdata),
      .mram_enable    (mram_enable),
      .mram_write_en  (mram_write_en),
      .mram_lb_enable (mram_lb_enable),
      .mram_ub_enable (mram_ub_enable),
      .mram_addr      (mram_addr),
      .mram_dq_out    (mram_dq_out),
      .mram_dq_oe     (mram_dq_oe),
      .mram_dq_in     (mram_dq_in)
`ifdef MRAM_ARB_CTRL_STATS_EN
      ,
      .stat_rd_cnt       (stat_rd_cnt),
      .stat_wr_cnt       (stat_wr_cnt),
      .stat_conflict_cnt (stat_conflict_cnt)
`endif
   );

   function automatic logic [15:0] init_pat(input int i);
      return 16'(i * 32'h1357) ^ 16'h5A5A;
   endfunction

   // Pin-level array: 16 words indexed by the low address bits, read data after RL cycles
   logic [15:0] arr     [16];
   logic [15:0] rd_pipe [RL];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) arr[i] <= init_pat(i);
      end else if (mram_enable && !mram_write_en) begin
         if (!mram_lb_enable) arr[mram_addr[3:0]][7:0]  <= mram_dq_out[7:0];
         if (!mram_ub_enable) arr[mram_addr[3:0]][15:8] <= mram_dq_out[15:8];
      end
      rd_pipe[0] <= (mram_enable && mram_write_en) ? arr[mram_addr[3:0]] : 16'hBEEF;
      for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign mram_dq_in = rd_pipe[RL-1];

   // Reference model state
   typedef struct { int cyc; bit port; logic [15:0] data; } rsp_t;
   rsp_t          rsp_q[$];
   int            rdy_log[$];
   int            en_log[$];
   logic [15:0]   ref_mem[16];
   int            cyc, chk_cnt, pass_cnt, fail_cnt;
   bit            ref_last;
   int            ref_free;
   int            acc_cyc;
   bit            acc_we;
   logic [1:0]    acc_be;
   logic [AW-1:0] acc_addr;
   logic [15:0]   acc_wd;
   logic [1:0]    acc_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs in the low phase, advance the model, step to next negedge
   task automatic tick();
      logic [1:0]  er;
      logic [15:0] m;
      int          a;
      bit          p;
      rsp_t        r;
      #1;
      er = 2'b00;
      if (!rst && cyc >= ref_free) begin
         if (v[0] && v[1]) er = ref_last ? 2'b01 : 2'b10;
         else              er = {v[1], v[0]};
      end
      chk("ready0", 32'(req0_ready), 32'(er[0]));
      chk("ready1", 32'(req1_ready), 32'(er[1]));
      if (req0_ready || req1_ready) rdy_log.push_back(int'(req1_ready));
      if (mram_enable) en_log.push_back(cyc);

      if (acc_cyc == cyc) begin
         chk("acc_enable",   32'(mram_enable),    32'(1'b1));
         chk("acc_write_en", 32'(mram_write_en),  32'(!acc_we));
         chk("acc_lb",       32'(mram_lb_enable), 32'(!acc_be[0]));
         chk("acc_ub",       32'(mram_ub_enable), 32'(!acc_be[1]));
         chk("acc_addr",     32'(mram_addr),      32'(acc_addr));
         chk("acc_oe",       32'(mram_dq_oe),     32'(acc_we));
         if (acc_we) chk("acc_dq_out", 32'(mram_dq_out), 32'(acc_wd));
      end else begin
         chk("idle_enable", 32'(mram_enable), 32'(1'b0));
         chk("idle_oe",     32'(mram_dq_oe),  32'(1'b0));
      end

      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
         r = rsp_q.pop_front();
         chk("rsp0_valid", 32'(rsp0_valid), 32'(!r.port));
         chk("rsp1_valid", 32'(rsp1_valid), 32'(r.port));
         if (r.port) chk("rsp1_rdata", 32'(rsp1_rdata), 32'(r.data));
         else        chk("rsp0_rdata", 32'(rsp0_rdata), 32'(r.data));
      end else begin
         chk("rsp0_quiet", 32'(rsp0_valid), 32'(1'b0));
         chk("rsp1_quiet", 32'(rsp1_valid), 32'(1'b0));
      end

      if (rst) begin
         ref_last = 1'b1;
         ref_free = cyc + 1;
         rsp_q.delete();
         acc_cyc  = -1;
      end else if (er != 2'b00) begin
         p        = er[1];
         ref_last = p;
         acc_cyc  = cyc + 1;
         acc_we   = we[p];
         acc_be   = be[p];
         acc_addr = addr[p];
         acc_wd   = wd[p];
         a        = int'(addr[p][3:0]);
         m        = {{8{be[p][1]}}, {8{be[p][0]}}};
         if (we[p]) begin
            ref_mem[a] = (ref_mem[a] & ~m) | (wd[p] & m);
            ref_free   = cyc + 2;
         end else begin
            rsp_q.push_back('{cyc + 3 + RL, p, ref_mem[a] & m});
            ref_free   = cyc + 3 + RL;
         end
      end
      acc_gnt = er;
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input int p, input bit w, input logic [1:0] b,
                       input logic [AW-1:0] ad, input logic [15:0] d);
      bit done;
      done    = 1'b0;
      v[p]    = 1'b1;
      we[p]   = w;
      be[p]   = b;
      addr[p] = ad;
      wd[p]   = d;
      for (int k = 0; k < 20 && !done; k++) begin
         tick();
         done = acc_gnt[p];
      end
      v[p] = 1'b0;
      chk("send_accepted", 32'(done), 32'(1'b1));
   endtask

   initial begin
      cyc = 0; chk_cnt = 0; pass_cnt = 0; fail_cnt = 0;
      ref_last = 1'b1; ref_free = 0; acc_cyc = -1; acc_gnt = 2'b00;
      acc_we = 1'b0; acc_be = 2'b00; acc_addr = '0; acc_wd = '0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_pat(i);
      for (int p = 0; p < 2; p++) begin
         v[p] = 1'b1; we[p] = 1'b0; be[p] = 2'b11; addr[p] = '0; wd[p] = '0;
      end

      // Reset with both requesters valid
      rst = 1'b1; mem_init = 1'b1;
      @(posedge clk); cyc = 1;
      @(negedge clk); mem_init = 1'b0;
      tick();
      #1;
      chk("rst_ready0",   32'(req0_ready),     32'(1'b0));
      chk("rst_ready1",   32'(req1_ready),     32'(1'b0));
      chk("rst_enable",   32'(mram_enable),    32'(1'b0));
      chk("rst_write_en", 32'(mram_write_en),  32'(1'b1));
      chk("rst_lb",       32'(mram_lb_enable), 32'(1'b1));
      chk("rst_ub",       32'(mram_ub_enable), 32'(1'b1));
      chk("rst_oe",       32'(mram_dq_oe),     32'(1'b0));
      chk("rst_addr",     32'(mram_addr),      32'(0));
      chk("rst_dq_out",   32'(mram_dq_out),    32'(0));
      chk("rst_rdata0",   32'(rsp0_rdata),     32'(0));
      chk("rst_rdata1",   32'(rsp1_rdata),     32'(0));
      tick();
      v[0] = 1'b0; v[1] = 1'b0; rst = 1'b0;
      idle(2);

      // Full-word write then masked read of the same word
      send(0, 1'b1, 2'b11, 20'h00010, 16'hA5C3);
      idle(2);
      send(1, 1'b0, 2'b01, 20'h00010, 16'h0000);
      idle(4);
      chk("read1_rdata_held", 32'(rsp1_rdata), 32'h00C3);

      // Continuous conflict: four reads must alternate starting with port 0
      rdy_log.delete();
      v[0] = 1'b1; we[0] = 1'b0; be[0] = 2'b11; addr[0] = 20'h00011;
      v[1] = 1'b1; we[1] = 1'b0; be[1] = 2'b10; addr[1] = 20'h00022;
      for (int k = 0; k < 60 && rdy_log.size() < 4; k++) tick();
      v[0] = 1'b0; v[1] = 1'b0;
      idle(6);
      chk("rr_count", 32'(rdy_log.size()), 32'(4));
      for (int i = 0; i < 4; i++) chk("rr_order", 32'(rdy_log[i]), 32'(i % 2));

      // Read then write back-to-back: array released before the write drives dq
      en_log.delete();
      send(0, 1'b0, 2'b11, 20'h00005, 16'h0000);
      send(0, 1'b1, 2'b10, 20'h00005, 16'h1234);
      idle(3);
      chk("rw_access_count", 32'(en_log.size()), 32'(2));
      chk("rw_access_gap",   32'(en_log[1] - en_log[0]), 32'(3 + RL));

      // Zero byte enables still run; a read returns zero with a response
      send(0, 1'b1, 2'b00, 20'h00007, 16'hFFFF);
      send(1, 1'b0, 2'b00, 20'h00007, 16'h0000);
      idle(5);
      send(0, 1'b0, 2'b11, 20'h00007, 16'h0000);
      idle(5);

      // Reset during WAIT drops the read; next request is served
      send(1, 1'b0, 2'b11, 20'h00003, 16'h0000);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef MRAM_ARB_CTRL_STATS_EN
      #1;
      chk("stat_rd_zero",       stat_rd_cnt,       32'(0));
      chk("stat_wr_zero",       stat_wr_cnt,       32'(0));
      chk("stat_conflict_zero", stat_conflict_cnt, 32'(0));
`endif
      idle(5);
      send(1, 1'b0, 2'b11, 20'h00003, 16'h0000);
      idle(5);

      // Random traffic with occasional resets
      for (int n = 0; n < 500; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (acc_gnt[p] || !v[p]) begin
               v[p]    = ($urandom_range(0, 3) != 0);
               we[p]   = 1'($urandom_range(0, 1));
               be[p]   = 2'($urandom_range(0, 3));
               addr[p] = AW'($urandom);
               wd[p]   = 16'($urandom);
            end
         end
         rst = ($urandom_range(0, 79) == 0);
         tick();
      end
      rst = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
      idle(8);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
